// File: rtl/reg_access_seq.sv
// rtl/reg_access_seq.sv - operand fetch / writeback sequencer for a single-port register file
// Optional: define RFSEQ_ZERO_REG_EN to make index 0 a hard-wired zero register.
module reg_access_seq #(
  parameter int REG_ID_LEN = 4,
  parameter int REG_SIZE   = 64,
  parameter int DEBUG      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ID_LEN-1:0] req_rs1,
  input  logic [REG_ID_LEN-1:0] req_rs2,
  input  logic [REG_ID_LEN-1:0] req_rd,
  input  logic                  req_wb,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [REG_SIZE-1:0]   op_a,
  output logic [REG_SIZE-1:0]   op_b,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_SIZE-1:0]   wb_value,
  output logic [REG_ID_LEN-1:0] rf_id,
  output logic                  rf_read,
  output logic                  rf_write,
  output logic [REG_SIZE-1:0]   rf_value,
  input  logic [REG_SIZE-1:0]   rf_out,
  output logic                  busy
);

`ifdef RFSEQ_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, ISSUE, WB_WAIT, WRITE} state_t;

  state_t                state;
  logic [REG_ID_LEN-1:0] rs2_q;
  logic [REG_ID_LEN-1:0] rd_q;
  logic                  wb_q;
  logic                  rf_write_q;

  function automatic logic real_reg(input logic [REG_ID_LEN-1:0] id);
    return !(ZERO_REG && (id == '0));
  endfunction

  // Reset wins over a WRITE in progress, so the register file never commits an aborted write.
  assign rf_write = rf_write_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      op_valid   <= 1'b0;
      wb_ready   <= 1'b0;
      rf_id      <= '0;
      rf_read    <= 1'b0;
      rf_write_q <= 1'b0;
      rf_value   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rs2_q     <= req_rs2;
            rd_q      <= req_rd;
            wb_q      <= req_wb;
            rf_id     <= req_rs1;
            rf_read   <= real_reg(req_rs1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= RD_A;
          end
        end
        // rf_read low here means a zero-register source: operand is 0, not rf_out.
        RD_A: begin
          op_a    <= rf_read ? rf_out : '0;
          rf_id   <= rs2_q;
          rf_read <= real_reg(rs2_q);
          state   <= RD_B;
        end
        RD_B: begin
          op_b     <= rf_read ? rf_out : '0;
          rf_id    <= '0;
          rf_read  <= 1'b0;
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            if (wb_q) begin
              wb_ready <= 1'b1;
              state    <= WB_WAIT;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        WB_WAIT: begin
          if (wb_valid) begin
            wb_ready   <= 1'b0;
            rf_id      <= rd_q;
            rf_value   <= wb_value;
            rf_write_q <= real_reg(rd_q);
            state      <= WRITE;
          end
        end
        WRITE: begin
          rf_id      <= '0;
          rf_value   <= '0;
          rf_write_q <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (DEBUG != 0) begin : g_debug
      always @(posedge clk) begin
        if (rf_write) $display("reg_access_seq: r%0d <= 0x%h", rf_id, rf_value);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_reg_access_seq.sv
// tb/tb_reg_access_seq.sv - directed self-checking bench for reg_access_seq with a behavioural register file
module tb_reg_access_seq;
  localparam int IDW = 4;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [IDW-1:0] req_rs1 = '0;
  logic [IDW-1:0] req_rs2 = '0;
  logic [IDW-1:0] req_rd = '0;
  logic           req_wb = 1'b0;
  logic           op_valid;
  logic           op_ready = 1'b0;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic           wb_valid = 1'b0;
  logic           wb_ready;
  logic [DW-1:0]  wb_value = '0;
  logic [IDW-1:0] rf_id;
  logic           rf_read;
  logic           rf_write;
  logic [DW-1:0]  rf_value;
  logic [DW-1:0]  rf_out;
  logic           busy;

  logic [DW-1:0]  rf [16];
  logic           pl_en = 1'b0;
  logic [IDW-1:0] pl_id = '0;
  logic [DW-1:0]  pl_val = '0;
  int             wr_count = 0;
  int             vectors = 0;
  int             miscompares = 0;
  int             w0;

`ifdef RFSEQ_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_access_seq #(.REG_ID_LEN(IDW), .REG_SIZE(DW), .DEBUG(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value),
    .rf_id(rf_id), .rf_read(rf_read), .rf_write(rf_write), .rf_value(rf_value),
    .rf_out(rf_out), .busy(busy)
  );

  assign rf_out = rf[rf_id];

  always @(posedge clk) begin
    if (rf_write) begin
      rf[rf_id] <= rf_value;
      wr_count  <= wr_count + 1;
    end else if (pl_en) begin
      rf[pl_id] <= pl_val;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_op_valid"}, DW'(op_valid), 0);
    chk({tag, "_wb_ready"}, DW'(wb_ready), 0);
    chk({tag, "_rf_read"}, DW'(rf_read), 0);
    chk({tag, "_rf_write"}, DW'(rf_write), 0);
    chk({tag, "_rf_id"}, DW'(rf_id), 0);
    chk({tag, "_rf_value"}, rf_value, 0);
    chk({tag, "_op_a"}, op_a, 0);
    chk({tag, "_op_b"}, op_b, 0);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_req_ready"}, DW'(req_ready), 1);
  endtask

  task automatic preload(input logic [IDW-1:0] id, input logic [DW-1:0] val);
    pl_en = 1'b1; pl_id = id; pl_val = val;
    tick();
    pl_en = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where the DUT is in RD_A.
  task automatic do_req(input logic [IDW-1:0] rs1, input logic [IDW-1:0] rs2,
                        input logic [IDW-1:0] rd, input logic wb);
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk_reset("init");
    rst = 1'b0;
    preload(3, 64'h11);
    preload(5, 64'h22);
    preload(1, 64'h1234);
    preload(0, 64'h99);

    // Plain fetch without writeback, latency counted cycle by cycle.
    do_req(3, 5, 0, 1'b0);
    chk("t1_rda_id", DW'(rf_id), 3);
    chk("t1_rda_read", DW'(rf_read), 1);
    chk("t1_rda_busy", DW'(busy), 1);
    chk("t1_rda_req_ready", DW'(req_ready), 0);
    chk("t1_rda_op_valid", DW'(op_valid), 0);
    tick();
    chk("t1_rdb_id", DW'(rf_id), 5);
    chk("t1_rdb_read", DW'(rf_read), 1);
    chk("t1_rdb_op_valid", DW'(op_valid), 0);
    tick();
    chk("t1_iss_op_valid", DW'(op_valid), 1);
    chk("t1_iss_op_a", op_a, 64'h11);
    chk("t1_iss_op_b", op_b, 64'h22);
    chk("t1_iss_read", DW'(rf_read), 0);
    chk("t1_iss_id", DW'(rf_id), 0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("t1_done_op_valid", DW'(op_valid), 0);
    chk("t1_done_busy", DW'(busy), 0);
    chk("t1_done_req_ready", DW'(req_ready), 1);
    chk("t1_done_wb_ready", DW'(wb_ready), 0);

    // Stray wb_valid in IDLE.
    w0 = wr_count;
    wb_valid = 1'b1; wb_value = 64'hBAD;
    tick();
    wb_valid = 1'b0;
    chk("idle_wb_busy", DW'(busy), 0);
    chk("idle_wb_req_ready", DW'(req_ready), 1);
    chk("idle_wb_wb_ready", DW'(wb_ready), 0);
    chk("idle_wb_writes", DW'(wr_count - w0), 0);

    // Writeback to r7 with operand back-pressure and a stray wb_valid in ISSUE.
    do_req(3, 5, 7, 1'b1);
    tick(); tick();
    chk("t2_iss_op_valid", DW'(op_valid), 1);
    wb_valid = 1'b1; wb_value = 64'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_op_valid", DW'(op_valid), 1);
      chk("t2_hold_op_a", op_a, 64'h11);
      chk("t2_hold_op_b", op_b, 64'h22);
      chk("t2_hold_wb_ready", DW'(wb_ready), 0);
    end
    wb_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("t2_wbw_wb_ready", DW'(wb_ready), 1);
    chk("t2_wbw_op_valid", DW'(op_valid), 0);
    chk("t2_wbw_busy", DW'(busy), 1);
    tick();
    chk("t2_wbw_still_waiting", DW'(wb_ready), 1);
    wb_valid = 1'b1; wb_value = 64'hABCD;
    tick();
    wb_valid = 1'b0;
    chk("t2_wr_rf_write", DW'(rf_write), 1);
    chk("t2_wr_rf_id", DW'(rf_id), 7);
    chk("t2_wr_rf_value", rf_value, 64'hABCD);
    chk("t2_wr_wb_ready", DW'(wb_ready), 0);
    chk("t2_wr_rf_read", DW'(rf_read), 0);
    tick();
    chk("t2_after_rf_write", DW'(rf_write), 0);
    chk("t2_after_busy", DW'(busy), 0);
    chk("t2_r7", rf[7], 64'hABCD);
    chk("t2_write_pulses", DW'(wr_count - w0), 1);

    // rs1==rs2 takes two reads; then write r2 and read it straight back.
    do_req(1, 1, 2, 1'b1);
    chk("t3_rda_id", DW'(rf_id), 1);
    chk("t3_rda_read", DW'(rf_read), 1);
    tick();
    chk("t3_rdb_id", DW'(rf_id), 1);
    chk("t3_rdb_read", DW'(rf_read), 1);
    op_ready = 1'b1;
    tick();
    chk("t3_op_a", op_a, 64'h1234);
    chk("t3_op_b", op_b, 64'h1234);
    tick();
    op_ready = 1'b0;
    chk("t3_wbw_wb_ready", DW'(wb_ready), 1);
    wb_valid = 1'b1; wb_value = 64'h55;
    tick();
    wb_valid = 1'b0;
    chk("t3_wr_rf_id", DW'(rf_id), 2);
    tick();
    chk("t3_r2", rf[2], 64'h55);
    do_req(2, 3, 0, 1'b0);
    tick(); tick();
    chk("t3_readback_op_a", op_a, 64'h55);
    chk("t3_readback_op_b", op_b, 64'h11);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Reset while in RD_B, then a writeback attempt that must be discarded.
    w0 = wr_count;
    do_req(3, 5, 4, 1'b1);
    tick();
    chk("t4_rdb_id", DW'(rf_id), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_rdb");
    wb_valid = 1'b1; wb_value = 64'hFACE;
    tick(); tick();
    wb_valid = 1'b0;
    chk("t4_rdb_writes", DW'(wr_count - w0), 0);
    chk("t4_rdb_busy", DW'(busy), 0);

    // Reset while in WRITE: the pending write to r3 must not commit.
    do_req(5, 5, 3, 1'b1);
    tick(); tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_value = 64'hEEEE;
    tick();
    wb_valid = 1'b0;
    chk("t4_wr_rf_write", DW'(rf_write), 1);
    rst = 1'b1;
    #1;
    chk("t4_wr_rf_write_gated", DW'(rf_write), 0);
    tick();
    rst = 1'b0;
    chk_reset("rst_wr");
    chk("t4_r3_kept", rf[3], 64'h11);
    tick();
    chk("t4_wr_writes", DW'(wr_count - w0), 0);

    // Index 0 as source and destination.
    do_req(0, 5, 0, 1'b1);
    chk("t5_rda_read", DW'(rf_read), ZR ? 0 : 1);
    tick(); tick();
    chk("t5_op_a", op_a, ZR ? 64'h0 : 64'h99);
    chk("t5_op_b", op_b, 64'h22);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_value = 64'h77;
    tick();
    wb_valid = 1'b0;
    chk("t5_wr_rf_write", DW'(rf_write), ZR ? 0 : 1);
    chk("t5_wr_busy", DW'(busy), 1);
    tick();
    chk("t5_after_busy", DW'(busy), 0);
    chk("t5_r0", rf[0], ZR ? 64'h99 : 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
